// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch-PC / branch-resolution slice.
//   F3_*         : B-type funct3 encodings
//   pcb_state_t  : pc_branch_unit state encoding
//   PC_STEP      : sequential fetch increment
package rv32i_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } pcb_state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational taken decoder.
//   valid_i               : execute-stage instruction valid
//   is_branch/jal/jalr_i  : instruction class
//   funct3_i              : branch funct3
//   br_less_i, br_equal_i : comparator results
//   taken_o               : control transfer is taken
module branch_cond
  import rv32i_pkg::*;
(
  input  logic       valid_i,
  input  logic       is_branch_i,
  input  logic       is_jal_i,
  input  logic       is_jalr_i,
  input  logic [2:0] funct3_i,
  input  logic       br_less_i,
  input  logic       br_equal_i,
  output logic       taken_o
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (funct3_i)
      F3_BEQ:           cond = br_equal_i;
      F3_BNE:           cond = !br_equal_i;
      F3_BLT, F3_BLTU:  cond = br_less_i;
      F3_BGE, F3_BGEU:  cond = !br_less_i;
      default:          cond = 1'b0;   // 010/011 are not branches
    endcase
  end

  // Jumps are unconditional, so the class priority only matters for the target.
  assign taken_o = valid_i & (is_jal_i | is_jalr_i | (is_branch_i & cond));

endmodule

// File: rtl/pc_branch_unit.sv
// Branch resolution and fetch PC register.
//   clk, rst_n (sync, active-low), stall
//   ex_* / rs1_data   : execute-stage instruction and operands
//   br_less/br_equal  : from brc;  br_un : to brc (funct3[1])
//   pc                : fetch PC
//   redirect          : one-cycle pulse when pc first shows a target
//   flush             : IF/ID squash, FLUSH_CYCLES long per redirect
//   trap, trap_pc     : sticky misaligned-target flag and offending ex_pc
module pc_branch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] rs1_data,
  input  logic        br_less,
  input  logic        br_equal,
  output logic        br_un,
  output logic [31:0] pc,
  output logic        redirect,
  output logic        flush,
  output logic        trap,
  output logic [31:0] trap_pc
);

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  pcb_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d, trap_pc_q, trap_pc_d;
  logic        redirect_q, redirect_d, flush_q, flush_d, trap_q, trap_d;

  logic        taken, misaligned;
  logic [31:0] target, pc_inc;

  branch_cond u_cond (
    .valid_i     (ex_valid),
    .is_branch_i (ex_is_branch),
    .is_jal_i    (ex_is_jal),
    .is_jalr_i   (ex_is_jalr),
    .funct3_i    (ex_funct3),
    .br_less_i   (br_less),
    .br_equal_i  (br_equal),
    .taken_o     (taken)
  );

  // JALR takes precedence for the target; JAL and B-type share pc-relative form.
  always_comb begin
    if (ex_is_jalr) target = (rs1_data + ex_imm) & ~32'h1;
    else            target = ex_pc + ex_imm;
  end

  assign misaligned = |target[1:0];
  assign pc_inc     = pc_q + PC_STEP;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      trap_q     <= 1'b0;
      trap_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
      trap_q     <= trap_d;
      trap_pc_q  <= trap_pc_d;
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    flush_d    = flush_q;
    trap_d     = trap_q;
    trap_pc_d  = trap_pc_q;
    case (state_q)
      ST_RUN: begin
        if (taken && !misaligned) begin
          pc_d       = target;        // overrides stall
          redirect_d = 1'b1;
          flush_d    = 1'b1;
          cnt_d      = CNT_INIT;
          state_d    = ST_FLUSH;
        end else if (taken) begin
          trap_d    = 1'b1;
          trap_pc_d = ex_pc;
          state_d   = ST_TRAP;
        end else if (!stall) begin
          pc_d = pc_inc;
        end
      end
      ST_FLUSH: begin
        // Instruction in execute is being squashed: its decision is ignored.
        if (!stall) pc_d = pc_inc;
        if (cnt_q == 4'd0) begin
          flush_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_TRAP: begin
        flush_d = 1'b0;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs
  always_comb begin
    br_un    = ex_funct3[1];
    pc       = pc_q;
    redirect = redirect_q;
    flush    = flush_q;
    trap     = trap_q;
    trap_pc  = trap_pc_q;
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_imm, rs1_data;
  logic        br_less, br_equal;
  logic        br_un, redirect, flush, trap;
  logic [31:0] pc, trap_pc;

  int errors = 0;
  int checks = 0;

  pc_branch_unit #(.RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm), .rs1_data(rs1_data),
    .br_less(br_less), .br_equal(br_equal), .br_un(br_un), .pc(pc),
    .redirect(redirect), .flush(flush), .trap(trap), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_funct3 = 3'b000; ex_pc = 0; ex_imm = 0; rs1_data = 0;
    br_less = 0; br_equal = 0; stall = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; tick(); rst_n = 1;
  endtask

  task automatic test_reset();
    clr(); rst_n = 0; tick(); tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc); end
    checks++; if ({redirect, flush, trap} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {redirect, flush, trap}); end
    checks++; if (trap_pc !== 32'h0) begin errors++; $display("FAIL reset_trap_pc got=%h exp=0", trap_pc); end
    rst_n = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc !== 32'(4*i) || {redirect, flush, trap} !== 3'b000) begin
        errors++; $display("FAIL seq_fetch%0d got=%h/%b exp=%h/000", i, pc, {redirect, flush, trap}, 32'(4*i)); end
    end
  endtask

  task automatic test_beq();
    clr(); ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b000;
    ex_pc = 32'h100; ex_imm = 32'h20; br_equal = 1;
    tick(); clr();
    checks++; if (pc !== 32'h120 || redirect !== 1 || flush !== 1) begin errors++; $display("FAIL beq_n1 got=%h r%b f%b exp=120 r1 f1", pc, redirect, flush); end
    tick();
    checks++; if (pc !== 32'h124 || redirect !== 0 || flush !== 1) begin errors++; $display("FAIL beq_n2 got=%h r%b f%b exp=124 r0 f1", pc, redirect, flush); end
    tick();
    checks++; if (pc !== 32'h128 || flush !== 0) begin errors++; $display("FAIL beq_n3 got=%h f%b exp=128 f0", pc, flush); end
    ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h100; ex_imm = 32'h20; br_equal = 0;
    tick(); clr();
    checks++; if (pc !== 32'h12C || redirect !== 0 || flush !== 0) begin errors++; $display("FAIL beq_nt got=%h r%b f%b exp=12c r0 f0", pc, redirect, flush); end
  endtask

  task automatic test_bltu();
    clr(); ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b110; br_less = 1;
    ex_pc = 32'h200; ex_imm = 32'h40; #1;
    checks++; if (br_un !== 1) begin errors++; $display("FAIL bltu_br_un got=%b exp=1", br_un); end
    tick(); clr();
    checks++; if (pc !== 32'h240 || redirect !== 1) begin errors++; $display("FAIL bltu_taken got=%h r%b exp=240 r1", pc, redirect); end
    tick(); tick();
    ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b100; br_less = 1;
    ex_pc = 32'h300; ex_imm = 32'hFFFF_FFF8; #1;
    checks++; if (br_un !== 0) begin errors++; $display("FAIL blt_br_un got=%b exp=0", br_un); end
    tick(); clr();
    checks++; if (pc !== 32'h2F8 || redirect !== 1) begin errors++; $display("FAIL blt_taken got=%h r%b exp=2f8 r1", pc, redirect); end
    tick(); tick();
  endtask

  // All funct3 codes under two comparator patterns.
  task automatic test_cond_table();
    logic [7:0]  tk_tab [2];
    logic [31:0] epc;
    logic [2:0]  f;
    tk_tab[0] = 8'b0101_0010;   // less=1 equal=0: BNE, BLT, BLTU
    tk_tab[1] = 8'b1010_0001;   // less=0 equal=1: BEQ, BGE, BGEU
    clr(); do_reset(); epc = 32'h0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) begin
        f = 3'(i);
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = f; ex_pc = 32'h400; ex_imm = 32'h10;
        br_less = (p == 0); br_equal = (p == 1); #1;
        checks++; if (br_un !== f[1]) begin errors++; $display("FAIL cond_br_un f3=%0d got=%b exp=%b", i, br_un, f[1]); end
        tick(); clr();
        epc = tk_tab[p][i] ? 32'h410 : epc + 4;
        checks++; if (pc !== epc || redirect !== tk_tab[p][i]) begin
          errors++; $display("FAIL cond p%0d f3=%0d got=%h r%b exp=%h r%b", p, i, pc, redirect, epc, tk_tab[p][i]); end
        if (tk_tab[p][i]) begin tick(); tick(); epc = epc + 8; end
      end
    end
  endtask

  task automatic test_flush_ignore();
    clr(); ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h500; ex_imm = 32'h100;
    tick();
    checks++; if (pc !== 32'h600 || flush !== 1) begin errors++; $display("FAIL fi_jal got=%h f%b exp=600 f1", pc, flush); end
    ex_pc = 32'h700; ex_imm = 32'h10;   // held valid through both flush cycles
    tick();
    checks++; if (pc !== 32'h604 || redirect !== 0 || flush !== 1) begin errors++; $display("FAIL fi_ign1 got=%h r%b f%b exp=604 r0 f1", pc, redirect, flush); end
    tick();
    checks++; if (pc !== 32'h608 || redirect !== 0 || flush !== 0) begin errors++; $display("FAIL fi_ign2 got=%h r%b f%b exp=608 r0 f0", pc, redirect, flush); end
    tick(); clr();
    checks++; if (pc !== 32'h710 || redirect !== 1 || flush !== 1) begin errors++; $display("FAIL fi_honour got=%h r%b f%b exp=710 r1 f1", pc, redirect, flush); end
    tick(); tick();
  endtask

  task automatic test_priority();
    clr(); ex_valid = 1; ex_is_jal = 1; ex_is_jalr = 1; ex_is_branch = 1;
    ex_pc = 32'h800; ex_imm = 32'h4; rs1_data = 32'h1000;
    tick(); clr();
    checks++; if (pc !== 32'h1004) begin errors++; $display("FAIL prio_jalr got=%h exp=1004", pc); end
    tick(); tick();
    ex_valid = 1; ex_is_jal = 1; ex_is_branch = 1; ex_funct3 = 3'b000; br_equal = 0;
    ex_pc = 32'h800; ex_imm = 32'h8; rs1_data = 32'h3000;
    tick(); clr();
    checks++; if (pc !== 32'h808 || redirect !== 1) begin errors++; $display("FAIL prio_jal got=%h r%b exp=808 r1", pc, redirect); end
    tick(); tick();
  endtask

  task automatic test_jalr_align();
    clr(); ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'h50; rs1_data = 32'h205; ex_imm = 32'hFFFF_FFFF;
    tick(); clr();
    checks++; if (pc !== 32'h204 || trap !== 0 || redirect !== 1) begin errors++; $display("FAIL jalr_align got=%h t%b r%b exp=204 t0 r1", pc, trap, redirect); end
    tick(); tick();
  endtask

  task automatic test_stall();
    clr(); stall = 1; ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h900; ex_imm = 32'h20;
    tick(); ex_valid = 0; ex_is_jal = 0;
    checks++; if (pc !== 32'h920 || redirect !== 1) begin errors++; $display("FAIL stall_jal got=%h r%b exp=920 r1", pc, redirect); end
    tick();
    checks++; if (pc !== 32'h920 || flush !== 1) begin errors++; $display("FAIL stall_fl1 got=%h f%b exp=920 f1", pc, flush); end
    tick();
    checks++; if (pc !== 32'h920 || flush !== 0) begin errors++; $display("FAIL stall_fl2 got=%h f%b exp=920 f0", pc, flush); end
    tick();
    checks++; if (pc !== 32'h920) begin errors++; $display("FAIL stall_run got=%h exp=920", pc); end
    stall = 0; tick();
    checks++; if (pc !== 32'h924) begin errors++; $display("FAIL stall_release got=%h exp=924", pc); end
  endtask

  task automatic test_wrap();
    clr(); ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h10; ex_imm = 32'hFFFF_FFE8;
    tick(); clr();
    checks++; if (pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_tgt got=%h exp=fffffff8", pc); end
    tick();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fc got=%h exp=fffffffc", pc); end
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", pc); end
  endtask

  task automatic test_reset_mid_flush();
    clr(); ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h40; ex_imm = 32'h40;
    tick(); clr();
    checks++; if (pc !== 32'h80 || flush !== 1) begin errors++; $display("FAIL rmf_pre got=%h f%b exp=80 f1", pc, flush); end
    rst_n = 0; tick();
    checks++; if (pc !== 32'h0 || flush !== 0 || redirect !== 0) begin errors++; $display("FAIL rmf_reset got=%h f%b r%b exp=0 f0 r0", pc, flush, redirect); end
    rst_n = 1; tick();
    checks++; if (pc !== 32'h4 || flush !== 0) begin errors++; $display("FAIL rmf_after got=%h f%b exp=4 f0", pc, flush); end
  endtask

  task automatic test_trap();
    int bad;
    clr(); do_reset(); tick();   // pc = 4
    ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'hA00; rs1_data = 32'h203; ex_imm = 32'h0;
    tick();
    checks++; if (trap !== 1 || trap_pc !== 32'hA00 || pc !== 32'h4 || flush !== 0 || redirect !== 0) begin
      errors++; $display("FAIL trap_rise got=t%b %h pc=%h f%b r%b exp=t1 a00 pc=4 f0 r0", trap, trap_pc, pc, flush, redirect); end
    // Further legal and illegal jumps must not disturb the frozen state.
    ex_is_jalr = 0; ex_is_jal = 1; ex_pc = 32'hC00; ex_imm = 32'h10;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 5) ex_imm = 32'h2;
      if (pc !== 32'h4 || trap !== 1 || trap_pc !== 32'hA00 || flush !== 0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL trap_frozen bad_cycles=%0d exp=0 (pc=%h tpc=%h)", bad, pc, trap_pc); end
    clr(); rst_n = 0; tick();
    checks++; if (trap !== 0 || trap_pc !== 32'h0 || pc !== 32'h0) begin errors++; $display("FAIL trap_reset got=t%b %h pc=%h exp=t0 0 0", trap, trap_pc, pc); end
    rst_n = 1;
    ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b001; br_equal = 0; ex_pc = 32'hB00; ex_imm = 32'h6;
    tick(); clr();
    checks++; if (trap !== 1 || trap_pc !== 32'hB00 || pc !== 32'h0) begin errors++; $display("FAIL trap_bne got=t%b %h pc=%h exp=t1 b00 0", trap, trap_pc, pc); end
  endtask

  initial begin
    rst_n = 0; clr();
    test_reset();
    test_beq();
    test_bltu();
    test_cond_table();
    test_flush_ignore();
    test_priority();
    test_jalr_align();
    test_stall();
    test_wrap();
    test_reset_mid_flush();
    test_trap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Branch-resolution and fetch-PC unit for the RV32I core, directly downstream of the branch comparator `brc`. Supplies `br_un` to `brc` from the execute-stage instruction, consumes `br_less`/`br_equal`, decides taken/not-taken for B-type, JAL and JALR, and owns the fetch PC register. On a redirect it loads the target and drives a multi-cycle pipeline flush. A misaligned target parks the unit in a sticky trap state.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch PC after reset
- `FLUSH_CYCLES`, 2, cycles `flush` stays high per redirect (legal range 1..15)

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  reset; **one clock; reset is synchronous and active-low**
- `stall`  in  1  hazard stall; holds `pc` when no redirect is pending
- `ex_valid`  in  1  execute-stage instruction valid
- `ex_is_branch`  in  1  B-type instruction
- `ex_is_jal`  in  1  JAL
- `ex_is_jalr`  in  1  JALR
- `ex_funct3`  in  3  branch funct3
- `ex_pc`  in  32  PC of the execute-stage instruction
- `ex_imm`  in  32  sign-extended immediate
- `rs1_data`  in  32  rs1 operand (JALR base)
- `br_less`  in  1  from `brc`
- `br_equal`  in  1  from `brc`
- `br_un`  out  1  to `brc`; combinational, equals `ex_funct3[1]`
- `pc`  out  32  fetch PC (registered)
- `redirect`  out  1  one-cycle pulse, high in the cycle `pc` first shows a target
- `flush`  out  1  squash IF/ID; registered
- `trap`  out  1  sticky misaligned-target flag
- `trap_pc`  out  32  `ex_pc` of the trapping instruction

## Operation
- Taken decision (combinational, only when `ex_valid`): JAL and JALR are always taken. For B-type, funct3 000 BEQ→`br_equal`; 001 BNE→`!br_equal`; 100 BLT and 110 BLTU→`br_less`; 101 BGE and 111 BGEU→`!br_less`. Codes 010 and 011 are not taken. With more than one `ex_is_*` set, JALR wins, then JAL, then branch.
- Target: branch/JAL = `ex_pc + ex_imm`; JALR = `(rs1_data + ex_imm) & ~32'h1`. Addition is 32-bit modulo with no overflow flag.
- Misaligned: a taken instruction whose `target[1:0] != 0`.
- States `RUN`, `FLUSH`, `TRAP`:
  - **RUN**
    - If taken and aligned: `pc←target`, `redirect←1`, `flush←1`, counter←`FLUSH_CYCLES-1`, go to FLUSH.
    - If taken and misaligned: `pc` held, `trap←1`, `trap_pc←ex_pc`, go to TRAP.
    - Otherwise: `pc←pc+4` unless `stall`.
  - **FLUSH**
    - `ex_valid` and the taken decision are ignored (the instruction is being squashed).
    - `pc←pc+4` unless `stall`.
    - Counter decrements every cycle, regardless of `stall`.
    - When the counter is 0 at the edge: `flush←0`, go to RUN.
  - **TRAP**: `pc`, `trap_pc` and `flush=0` are frozen. The only exit is reset.
- A redirect overrides `stall`.
- `pc+4` wraps: 32'hFFFF_FFFC → 32'h0000_0000.

## Timing
- Reset values (first edge with `rst_n=0`): `pc=RESET_PC`, `redirect=0`, `flush=0`, `trap=0`, `trap_pc=0`, state RUN, counter 0.
- Reset mid-FLUSH or in TRAP returns to RUN on that edge.
- Redirect latency: decision in cycle N. In cycle N+1, `pc=target`, `redirect=1` and `flush=1`. `flush` stays high for exactly `FLUSH_CYCLES` cycles, N+1 through N+`FLUSH_CYCLES`.
- A taken instruction in the last FLUSH cycle is ignored. A taken instruction in the first RUN cycle after it is honoured.
- `br_un` is purely combinational from `ex_funct3`, so `brc` resolves in the same cycle.
- `trap` rises in cycle N+1 and stays high.

## Structure
- Shared package `rv32i_pkg`:
  - funct3 branch encodings (`F3_BEQ` … `F3_BGEU`)
  - state enum `pcb_state_t`
  - constant `PC_STEP = 4`
- Sub-module `branch_cond`: combinational taken decoder mapping funct3, `br_less`, `br_equal` and the `is_*` bits to `taken`.
- The top level holds the target adders, state machine, counter and registers.

## Test plan
- **Reset and sequential fetch:** reset low 2 cycles then high, no `ex_valid` → `pc` = 0, 4, 8, 12 on successive cycles; `flush`, `redirect` and `trap` stay 0.
- **BEQ taken and not taken:** `ex_pc=0x100`, `imm=0x20`, `br_equal=1` → next cycle `pc=0x120`, `redirect` high for 1 cycle, `flush` high for 2 cycles, then `pc=0x124`, 0x128. Repeat with `br_equal=0` → `pc+4`, no flush.
- **BLTU `br_un` path:** `funct3=110` → `br_un=1`; `br_less=1` → taken. Same with `funct3=100` → `br_un=0`.
- **JALR alignment:** `rs1=0x203`, `imm=0` → target 0x202, which is misaligned → `trap=1`, `trap_pc=ex_pc`, `pc` frozen for 10 cycles. With `rs1=0x205`, `imm=-1` → `pc=0x204`, no trap.
- **Stall interactions:**
  - `stall=1` while a JAL is taken → `pc` still loads the target.
  - `stall` held throughout FLUSH → `pc` holds at the target, and `flush` still drops after `FLUSH_CYCLES` cycles.
- **Wrap and reset mid-flush:** with `pc=0xFFFF_FFFC`, the next `pc` is 0. Asserting `rst_n=0` in the first FLUSH cycle → next cycle `pc=RESET_PC`, `flush=0`, `redirect=0`.
